// File: rtl/hrm_mm_mc_if.sv
// Slink ingress and EMIF read-port signal bundle for hrm_mm_mc.
// master = upstream FIFO + EMIF host side, slave = hrm_mm_mc.
interface hrm_mm_mc_if #(
  parameter int AW = 9
);
  logic          slink_mm_empty;
  logic          mm_slink_rdreq;
  logic          slink_mm_dval;
  logic [17:0]   slink_mm_data;
  logic [3:0]    rd_chn_sel;
  logic [3:0]    rd_pkt_num;
  logic [AW-1:0] rd_addr;
  logic [17:0]   rd_data;

  modport master (
    output slink_mm_empty, slink_mm_dval, slink_mm_data,
    output rd_chn_sel, rd_pkt_num, rd_addr,
    input  mm_slink_rdreq, rd_data
  );

  modport slave (
    input  slink_mm_empty, slink_mm_dval, slink_mm_data,
    input  rd_chn_sel, rd_pkt_num, rd_addr,
    output mm_slink_rdreq, rd_data
  );
endinterface

// File: rtl/hrm_mm_mc.sv
// Ping/pong packet store per (channel, slot); slink writes inactive bank, EMIF reads active bank.
// Latency: commit toggles bank on EOP edge; rd_data registered, 1 cycle. Optional HRM_MM_DLY_CHK_EN timers.
// Backpressure: none; rdreq = ~empty, every dval word is consumed.
module hrm_mm_mc #(
  parameter int CHN_NUM   = 2,
  parameter int PKT_NUM   = 16,
  parameter int PKT_DEPTH = 512,
  parameter int TIMEOUT   = 100000
) (
  input  logic               clk_100m,
  input  logic               rst_100m_n,
  hrm_mm_mc_if.slave         bus,
  output logic               mm_pkt_err,
  output logic [CHN_NUM-1:0] mm_delay_err
);
  localparam int AW     = $clog2(PKT_DEPTH);
  localparam int NSLOT  = CHN_NUM * PKT_NUM;
  localparam int SIW    = (NSLOT > 1) ? $clog2(NSLOT) : 1;
  localparam int MDEPTH = NSLOT * 2 * PKT_DEPTH;
  localparam int MW     = $clog2(MDEPTH);
  localparam logic [4:0]  CHN_LIM  = 5'(CHN_NUM);
  localparam logic [4:0]  PKT_LIM  = 5'(PKT_NUM);
  localparam logic [AW:0] PTR_FULL = (AW+1)'(PKT_DEPTH);
  localparam logic [AW:0] PTR_ONE  = (AW+1)'(1);

  typedef enum logic [1:0] {IDLE, DATA, DROP} state_t;

  state_t           r_state, w_state_nxt;
  logic [AW:0]      r_ptr, w_ptr_nxt;
  logic [3:0]       r_chn, w_chn_nxt;
  logic [3:0]       r_slot, w_slot_nxt;
  logic [NSLOT-1:0] r_active;
  logic [17:0]      r_mem [MDEPTH];
  logic [17:0]      r_rd_data;
  logic             r_pkt_err;
  logic             w_err, w_we, w_commit;

  function automatic logic [SIW-1:0] f_sidx(input logic [3:0] chn, input logic [3:0] slot);
    return SIW'(int'(chn) * PKT_NUM + int'(slot));
  endfunction

  logic           w_sop, w_eop, w_hdr_ok;
  logic [3:0]     w_hchn, w_hslot;
  logic [SIW-1:0] w_cur_sidx;
  logic           w_wbank;
  logic [MW-1:0]  w_waddr;

  assign w_sop      = bus.slink_mm_data[17];
  assign w_eop      = bus.slink_mm_data[16];
  assign w_hchn     = bus.slink_mm_data[11:8];
  assign w_hslot    = bus.slink_mm_data[3:0];
  assign w_hdr_ok   = ({1'b0, w_hchn} < CHN_LIM) && ({1'b0, w_hslot} < PKT_LIM) && !w_eop;
  assign w_cur_sidx = f_sidx(r_chn, r_slot);
  assign w_wbank    = ~r_active[w_cur_sidx];
  assign w_waddr    = MW'((int'(w_cur_sidx) * 2 + int'(w_wbank)) * PKT_DEPTH + int'(r_ptr[AW-1:0]));

  assign bus.mm_slink_rdreq = rst_100m_n & ~bus.slink_mm_empty;

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_chn_nxt   = r_chn;
    w_slot_nxt  = r_slot;
    w_err       = 1'b0;
    w_we        = 1'b0;
    w_commit    = 1'b0;
    if (bus.slink_mm_dval) begin
      // A SOP inside DATA aborts the current packet and is re-decoded as a fresh header.
      if (w_sop && r_state != DROP) begin
        if (r_state == DATA) w_err = 1'b1;
        if (w_hdr_ok) begin
          w_state_nxt = DATA;
          w_ptr_nxt   = '0;
          w_chn_nxt   = w_hchn;
          w_slot_nxt  = w_hslot;
        end else begin
          w_err       = 1'b1;
          w_state_nxt = w_eop ? IDLE : DROP;
        end
      end else begin
        case (r_state)
          DATA: begin
            if (r_ptr == PTR_FULL) begin
              w_err       = 1'b1;
              w_state_nxt = w_eop ? IDLE : DROP;
            end else begin
              w_we      = 1'b1;
              w_ptr_nxt = r_ptr + PTR_ONE;
              if (w_eop) begin
                w_commit    = 1'b1;
                w_state_nxt = IDLE;
              end
            end
          end
          DROP: if (w_eop) w_state_nxt = IDLE;
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk_100m or negedge rst_100m_n) begin
    if (!rst_100m_n) begin
      r_state   <= IDLE;
      r_ptr     <= '0;
      r_chn     <= '0;
      r_slot    <= '0;
      r_active  <= '0;
      r_pkt_err <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_ptr     <= w_ptr_nxt;
      r_chn     <= w_chn_nxt;
      r_slot    <= w_slot_nxt;
      r_pkt_err <= w_err;
      if (w_commit) r_active[w_cur_sidx] <= ~r_active[w_cur_sidx];
    end
  end

  always_ff @(posedge clk_100m) begin
    if (w_we) r_mem[w_waddr] <= bus.slink_mm_data;
  end

  logic           w_rd_ok, w_rd_bank;
  logic [SIW-1:0] w_rd_sidx;
  logic [MW-1:0]  w_raddr;

  assign w_rd_ok   = ({1'b0, bus.rd_chn_sel} < CHN_LIM) && ({1'b0, bus.rd_pkt_num} < PKT_LIM);
  assign w_rd_sidx = f_sidx(bus.rd_chn_sel, bus.rd_pkt_num);
  assign w_rd_bank = w_rd_ok & r_active[w_rd_sidx];
  assign w_raddr   = MW'((int'(w_rd_sidx) * 2 + int'(w_rd_bank)) * PKT_DEPTH + int'(bus.rd_addr));

  // Bank bit is taken before this edge's commit, so a same-cycle commit still reads the old bank.
  always_ff @(posedge clk_100m or negedge rst_100m_n) begin
    if (!rst_100m_n) r_rd_data <= '0;
    else             r_rd_data <= w_rd_ok ? r_mem[w_raddr] : 18'h0;
  end

  assign bus.rd_data = r_rd_data;
  assign mm_pkt_err  = r_pkt_err;

`ifdef HRM_MM_DLY_CHK_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT);
  localparam logic [TW-1:0] TONE = TW'(1);
  for (genvar c = 0; c < CHN_NUM; c++) begin : g_tmr
    logic [TW-1:0] r_timer;
    always_ff @(posedge clk_100m or negedge rst_100m_n) begin
      if (!rst_100m_n)                     r_timer <= '0;
      else if (w_commit && r_chn == 4'(c)) r_timer <= '0;
      else if (r_timer != TMAX)            r_timer <= r_timer + TONE;
    end
    assign mm_delay_err[c] = (r_timer == TMAX);
  end
`else
  assign mm_delay_err = '0;
`endif
endmodule

// File: tb/tb_hrm_mm_mc.sv
// Directed bench for hrm_mm_mc: table of EMIF read vectors plus hand-written packet sequences.
module tb_hrm_mm_mc;
  localparam int CHN_NUM = 2, PKT_NUM = 16, PKT_DEPTH = 16, TIMEOUT = 50, AW = 4;
`ifdef HRM_MM_DLY_CHK_EN
  localparam bit DLY_EN = 1'b1;
`else
  localparam bit DLY_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  logic pkt_err;
  logic [CHN_NUM-1:0] delay_err;

  hrm_mm_mc_if #(.AW(AW)) bus ();

  hrm_mm_mc #(.CHN_NUM(CHN_NUM), .PKT_NUM(PKT_NUM), .PKT_DEPTH(PKT_DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk_100m(clk), .rst_100m_n(rst_n), .bus(bus), .mm_pkt_err(pkt_err), .mm_delay_err(delay_err)
  );

  initial forever #5 clk = ~clk;

  typedef struct {
    logic [3:0]  chn;
    logic [3:0]  slot;
    logic [3:0]  addr;
    logic [17:0] exp;
  } rd_vec_t;

  rd_vec_t     tbl[$];
  logic [17:0] q[$];
  int n_chk = 0, n_err = 0, n_pulse = 0, e0;

  always @(negedge clk) if (pkt_err === 1'b1) n_pulse++;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [17:0] sop(input logic [3:0] c, input logic [3:0] s);
    return {2'b10, 4'h0, c, 4'h0, s};
  endfunction
  function automatic logic [17:0] dw(input logic [15:0] d);
    return {2'b00, d};
  endfunction
  function automatic logic [17:0] eop(input logic [15:0] d);
    return {2'b01, d};
  endfunction

  function automatic rd_vec_t rv(input logic [3:0] c, input logic [3:0] s, input logic [3:0] a, input logic [17:0] e);
    rd_vec_t v;
    v.chn = c; v.slot = s; v.addr = a; v.exp = e;
    return v;
  endfunction

  // Upstream FIFO model: rdreq in one cycle, word valid the next.
  task automatic flush();
    int n;
    n = q.size();
    for (int k = 0; k <= n; k++) begin
      @(negedge clk);
      bus.slink_mm_empty = (k < n) ? 1'b0 : 1'b1;
      bus.slink_mm_dval  = (k > 0);
      bus.slink_mm_data  = (k > 0) ? q[k-1] : 18'h0;
      if (k == 0) begin
        #1;
        chk("rdreq_follows_empty", {31'd0, bus.mm_slink_rdreq}, 32'd1);
      end
    end
    @(negedge clk);
    bus.slink_mm_dval = 1'b0;
    bus.slink_mm_data = 18'h0;
    q.delete();
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic run_tbl(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      bus.rd_chn_sel = tbl[i].chn;
      bus.rd_pkt_num = tbl[i].slot;
      bus.rd_addr    = tbl[i].addr;
      @(negedge clk);
      chk($sformatf("rd[%0d] c%0d s%0d a%0d", i, tbl[i].chn, tbl[i].slot, tbl[i].addr),
          {14'd0, bus.rd_data}, {14'd0, tbl[i].exp});
    end
  endtask

  initial begin
    // 0-5 basic, 6-7 overflow, 8-9 full length, 10-13 abort, 14-16 invalid, 17-19 reset
    tbl.push_back(rv(1, 3, 0, 18'h0A000));
    tbl.push_back(rv(1, 3, 1, 18'h0A001));
    tbl.push_back(rv(1, 3, 2, 18'h0A002));
    tbl.push_back(rv(1, 3, 3, 18'h1A003));
    tbl.push_back(rv(2, 3, 0, 18'h00000));
    tbl.push_back(rv(15, 0, 0, 18'h00000));
    tbl.push_back(rv(1, 3, 0, 18'h0A000));
    tbl.push_back(rv(1, 3, 3, 18'h1A003));
    tbl.push_back(rv(1, 3, 0, 18'h0C000));
    tbl.push_back(rv(1, 3, 15, 18'h1C00F));
    tbl.push_back(rv(0, 2, 0, 18'h0D000));
    tbl.push_back(rv(0, 2, 1, 18'h1D001));
    tbl.push_back(rv(0, 5, 0, 18'h0F000));
    tbl.push_back(rv(0, 5, 1, 18'h1F001));
    tbl.push_back(rv(1, 7, 0, 18'h14444));
    tbl.push_back(rv(0, 2, 0, 18'h0D000));
    tbl.push_back(rv(0, 2, 1, 18'h1D001));
    tbl.push_back(rv(0, 5, 0, 18'h07000));
    tbl.push_back(rv(0, 5, 0, 18'h08000));
    tbl.push_back(rv(0, 5, 1, 18'h18001));

    rst_n = 1'b0;
    bus.slink_mm_empty = 1'b0;
    bus.slink_mm_dval  = 1'b0;
    bus.slink_mm_data  = 18'h0;
    bus.rd_chn_sel = 4'd0; bus.rd_pkt_num = 4'd0; bus.rd_addr = '0;
    idle(3);
    chk("reset_rd_data", {14'd0, bus.rd_data}, 32'd0);
    chk("reset_pkt_err", {31'd0, pkt_err}, 32'd0);
    chk("reset_delay_err", {30'd0, delay_err}, 32'd0);
    chk("reset_rdreq", {31'd0, bus.mm_slink_rdreq}, 32'd0);
    bus.slink_mm_empty = 1'b1;
    rst_n = 1'b1;

    // Timer reaches TIMEOUT on the 50th edge after release.
    repeat (49) @(posedge clk);
    @(negedge clk);
    chk("delay_err_cycle49", {30'd0, delay_err}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk("delay_err_cycle50", {30'd0, delay_err}, DLY_EN ? 32'd3 : 32'd0);

    e0 = n_pulse;
    q = '{sop(1, 3), dw(16'hA000), dw(16'hA001), dw(16'hA002), eop(16'hA003)};
    flush(); idle(2);
    chk("basic_no_err", n_pulse - e0, 32'd0);
    chk("commit_clears_dly1", {30'd0, delay_err}, DLY_EN ? 32'd1 : 32'd0);
    run_tbl(0, 5);

    e0 = n_pulse;
    q.push_back(sop(1, 3));
    for (int i = 0; i <= PKT_DEPTH; i++) q.push_back(dw(16'hB000 + 16'(i)));
    q.push_back(eop(16'hB0FF));
    flush(); idle(2);
    chk("overflow_one_err", n_pulse - e0, 32'd1);
    run_tbl(6, 7);

    e0 = n_pulse;
    q.push_back(sop(1, 3));
    for (int i = 0; i < PKT_DEPTH - 1; i++) q.push_back(dw(16'hC000 + 16'(i)));
    q.push_back(eop(16'hC00F));
    flush(); idle(2);
    chk("full_length_no_err", n_pulse - e0, 32'd0);
    run_tbl(8, 9);

    chk("dly0_before_commit", {31'd0, delay_err[0]}, DLY_EN ? 32'd1 : 32'd0);
    e0 = n_pulse;
    q = '{sop(0, 2), dw(16'hD000), eop(16'hD001)};
    flush(); idle(2);
    chk("commit_clears_dly0", {31'd0, delay_err[0]}, 32'd0);
    chk("slot2_no_err", n_pulse - e0, 32'd0);
    e0 = n_pulse;
    q = '{sop(0, 2), dw(16'hE000), dw(16'hE001), dw(16'hE002), sop(0, 5), dw(16'hF000), eop(16'hF001)};
    flush(); idle(2);
    chk("abort_one_err", n_pulse - e0, 32'd1);
    run_tbl(10, 13);

    e0 = n_pulse;
    q = '{{2'b10, 16'h0401}, dw(16'h1111), dw(16'h2222), eop(16'h3333), sop(1, 7), eop(16'h4444)};
    flush(); idle(2);
    chk("bad_chn_one_err", n_pulse - e0, 32'd1);
    e0 = n_pulse;
    q = '{{2'b11, 16'h0002}};
    flush(); idle(2);
    chk("zero_len_one_err", n_pulse - e0, 32'd1);
    run_tbl(14, 16);

    run_tbl(8, 8);
    q = '{sop(0, 5), dw(16'h7000), dw(16'h7001)};
    flush();
    e0 = n_pulse;
    bus.slink_mm_empty = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("midpkt_rst_rd_data", {14'd0, bus.rd_data}, 32'd0);
    chk("midpkt_rst_rdreq", {31'd0, bus.mm_slink_rdreq}, 32'd0);
    chk("midpkt_rst_pkt_err", {31'd0, pkt_err}, 32'd0);
    chk("midpkt_rst_delay_err", {30'd0, delay_err}, 32'd0);
    idle(2);
    bus.slink_mm_empty = 1'b1;
    rst_n = 1'b1;
    idle(2);
    chk("rst_no_err", n_pulse - e0, 32'd0);
    run_tbl(17, 17);
    e0 = n_pulse;
    q = '{sop(0, 5), dw(16'h8000), eop(16'h8001)};
    flush(); idle(2);
    chk("post_rst_no_err", n_pulse - e0, 32'd0);
    run_tbl(18, 19);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
